intr_sequencer: RTL and testbench

- CPU-side consumer of the Interrupt Controller's 6-bit request bus.
- Recognises a request at an instruction boundary and drives the controller's ISR_ld, current_ISR_num_ld and ISR_clr strobes.
- Runs a context save/restore handshake with the CPU datapath and supplies the vector address.
- Sits between the Interrupt Controller and the CPU control unit.

---
 rtl/intr_sequencer.sv | 166 ++++++++++++++++
 tb/tb_intr_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/intr_sequencer.sv
// intr_sequencer: CPU-side entry/exit sequencer for the interrupt controller's 6-bit request bus.
// Optional one-level preemption of a normal handler by a fast request: define INTR_NEST_EN.
module intr_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE  = 16'h0100,
    parameter int                VEC_SHIFT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        intr_In,
    input  logic              int_en,
    input  logic              instr_done,
    input  logic              reti,
    input  logic              ctx_ack,
    output logic              ISR_ld,
    output logic              current_ISR_num_ld,
    output logic              ISR_clr,
    output logic              ctx_save_req,
    output logic              ctx_restore_req,
    output logic              vec_valid,
    output logic [ADDR_W-1:0] vector_addr,
    output logic [2:0]        active_idx,
    output logic              in_service,
    output logic [1:0]        nest_depth
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_LOAD, S_NUM_LD, S_SAVE, S_SAVE_END,
        S_VECTOR, S_SERVICE, S_RESTORE, S_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        active_idx_q, active_idx_d;
    logic [ADDR_W-1:0] vector_addr_q, vector_addr_d;
    logic              in_service_q, in_service_d;
    logic [1:0]        nest_depth_q, nest_depth_d;
`ifdef INTR_NEST_EN
    logic [2:0]        stack_q, stack_d;
`endif

    // Lowest set bit wins: bit 0 is the highest-priority fast request.
    function automatic logic [2:0] encode(input logic [5:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [ADDR_W-1:0] vecAddr(input logic [2:0] idx);
        return VEC_BASE + (ADDR_W'(idx) << VEC_SHIFT);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            active_idx_q  <= 3'd0;
            vector_addr_q <= '0;
            in_service_q  <= 1'b0;
            nest_depth_q  <= 2'd0;
`ifdef INTR_NEST_EN
            stack_q       <= 3'd0;
`endif
        end else begin
            state_q       <= state_d;
            active_idx_q  <= active_idx_d;
            vector_addr_q <= vector_addr_d;
            in_service_q  <= in_service_d;
            nest_depth_q  <= nest_depth_d;
`ifdef INTR_NEST_EN
            stack_q       <= stack_d;
`endif
        end
    end

    always_comb begin
        state_d            = state_q;
        active_idx_d       = active_idx_q;
        vector_addr_d      = vector_addr_q;
        in_service_d       = in_service_q;
        nest_depth_d       = nest_depth_q;
`ifdef INTR_NEST_EN
        stack_d            = stack_q;
`endif
        ISR_ld             = 1'b0;
        current_ISR_num_ld = 1'b0;
        ISR_clr            = 1'b0;
        ctx_save_req       = 1'b0;
        ctx_restore_req    = 1'b0;
        vec_valid          = 1'b0;

        case (state_q)
            S_IDLE, S_WAIT: begin
                // The index is captured on the way into LOAD so it stays frozen from then on.
                if (!int_en || intr_In == 6'd0) begin
                    state_d = S_IDLE;
                end else if (instr_done) begin
                    state_d      = S_LOAD;
                    active_idx_d = encode(intr_In);
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_LOAD: begin
                ISR_ld  = 1'b1;
                state_d = S_NUM_LD;
            end
            S_NUM_LD: begin
                current_ISR_num_ld = 1'b1;
                nest_depth_d       = nest_depth_q + 2'd1;
                state_d            = S_SAVE;
            end
            S_SAVE: begin
                ctx_save_req = 1'b1;
                if (ctx_ack) state_d = S_SAVE_END;
            end
            S_SAVE_END: begin
                state_d       = S_VECTOR;
                vector_addr_d = vecAddr(active_idx_q);
                in_service_d  = 1'b1;
            end
            S_VECTOR: begin
                vec_valid = 1'b1;
                state_d   = S_SERVICE;
            end
            S_SERVICE: begin
                if (reti) begin
                    state_d = S_RESTORE;
`ifdef INTR_NEST_EN
                end else if (active_idx_q >= 3'd3 && int_en && intr_In[2:0] != 3'd0 && instr_done) begin
                    stack_d      = active_idx_q;
                    active_idx_d = encode({3'd0, intr_In[2:0]});
                    state_d      = S_LOAD;
`endif
                end
            end
            S_RESTORE: begin
                ctx_restore_req = 1'b1;
                if (ctx_ack) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                ISR_clr      = 1'b1;
                nest_depth_d = nest_depth_q - 2'd1;
                in_service_d = 1'b0;
                state_d      = S_IDLE;
`ifdef INTR_NEST_EN
                // Returning from the fast handler resumes the preempted normal one.
                if (nest_depth_q > 2'd1) begin
                    in_service_d  = 1'b1;
                    active_idx_d  = stack_q;
                    vector_addr_d = vecAddr(stack_q);
                    state_d       = S_VECTOR;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign vector_addr = vector_addr_q;
    assign active_idx  = active_idx_q;
    assign in_service  = in_service_q;
    assign nest_depth  = nest_depth_q;

endmodule

// File: tb/tb_intr_sequencer.sv
// tb_intr_sequencer: directed self-checking bench for intr_sequencer (either INTR_NEST_EN setting).
module tb_intr_sequencer;

    logic        clk;
    logic        reset;
    logic [5:0]  intr_In;
    logic        int_en, instr_done, reti, ctx_ack;
    logic        ISR_ld, current_ISR_num_ld, ISR_clr;
    logic        ctx_save_req, ctx_restore_req, vec_valid;
    logic [15:0] vector_addr;
    logic [2:0]  active_idx;
    logic        in_service;
    logic [1:0]  nest_depth;

    int nCompared   = 0;
    int nMismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    intr_sequencer dut (
        .clk(clk), .reset(reset), .intr_In(intr_In), .int_en(int_en),
        .instr_done(instr_done), .reti(reti), .ctx_ack(ctx_ack),
        .ISR_ld(ISR_ld), .current_ISR_num_ld(current_ISR_num_ld), .ISR_clr(ISR_clr),
        .ctx_save_req(ctx_save_req), .ctx_restore_req(ctx_restore_req),
        .vec_valid(vec_valid), .vector_addr(vector_addr), .active_idx(active_idx),
        .in_service(in_service), .nest_depth(nest_depth)
    );

    // Strobe vector order: ISR_ld, num_ld, ISR_clr, save_req, restore_req, vec_valid.
    function automatic logic [5:0] strobes();
        return {ISR_ld, current_ISR_num_ld, ISR_clr, ctx_save_req, ctx_restore_req, vec_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs for the current cycle, then move to just after the next rising edge.
    task automatic applyStimulus(input logic [5:0] intr, input logic en, input logic done,
                                 input logic ret, input logic ack);
        intr_In    = intr;
        int_en     = en;
        instr_done = done;
        reti       = ret;
        ctx_ack    = ack;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        assert (got === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered in the LOAD cycle; leaves the sequencer in SERVICE.
    task automatic runEntry(input logic [5:0] intr, input logic [2:0] expIdx,
                            input logic [15:0] expAddr, input logic [1:0] expDepth, input string tag);
        checkOutput({tag, ".load"}, strobes(), 6'b100000);
        checkOutput({tag, ".idx"}, active_idx, expIdx);
        applyStimulus(intr, 1, 0, 0, 0);
        checkOutput({tag, ".numld"}, strobes(), 6'b010000);
        applyStimulus(intr, 1, 0, 0, 0);
        checkOutput({tag, ".save"}, strobes(), 6'b000100);
        checkOutput({tag, ".depth"}, nest_depth, expDepth);
        applyStimulus(intr, 1, 0, 0, 1);
        checkOutput({tag, ".savedrop"}, strobes(), 6'b000000);
        applyStimulus(intr, 1, 0, 0, 0);
        checkOutput({tag, ".vec"}, strobes(), 6'b000001);
        checkOutput({tag, ".addr"}, vector_addr, expAddr);
        checkOutput({tag, ".insvc"}, in_service, 1'b1);
        applyStimulus(intr, 1, 0, 0, 0);
        checkOutput({tag, ".service"}, strobes(), 6'b000000);
        checkOutput({tag, ".addrhold"}, vector_addr, expAddr);
    endtask

    // Entered in SERVICE at depth 1; leaves the sequencer idle (or waiting on intr).
    task automatic finishService(input logic [5:0] intr, input string tag);
        applyStimulus(intr, 1, 0, 1, 0);
        checkOutput({tag, ".restore"}, strobes(), 6'b000010);
        applyStimulus(intr, 1, 0, 0, 0);
        checkOutput({tag, ".restorehold"}, strobes(), 6'b000010);
        applyStimulus(intr, 1, 0, 0, 1);
        checkOutput({tag, ".clr"}, strobes(), 6'b001000);
        applyStimulus(intr, 1, 0, 0, 0);
        checkOutput({tag, ".idle"}, strobes(), 6'b000000);
        checkOutput({tag, ".insvc0"}, in_service, 1'b0);
        checkOutput({tag, ".depth0"}, nest_depth, 2'd0);
        applyStimulus(intr, 1, 0, 0, 0);
        checkOutput({tag, ".clronce"}, strobes(), 6'b000000);
    endtask

    initial begin
        reset = 1'b1;
        intr_In = 6'd0; int_en = 1'b0; instr_done = 1'b0; reti = 1'b0; ctx_ack = 1'b0;
        tick();
        tick();
        checkOutput("rst.strobes", strobes(), 6'b000000);
        checkOutput("rst.addr", vector_addr, 16'h0000);
        checkOutput("rst.idx", active_idx, 3'd0);
        checkOutput("rst.insvc", in_service, 1'b0);
        checkOutput("rst.depth", nest_depth, 2'd0);
        reset = 1'b0;
        tick();

        // Reset while waiting for the save acknowledge.
        applyStimulus(6'b000001, 1, 1, 0, 0);
        checkOutput("midrst.load", strobes(), 6'b100000);
        applyStimulus(6'b000001, 1, 0, 0, 0);
        applyStimulus(6'b000001, 1, 0, 0, 0);
        checkOutput("midrst.save", strobes(), 6'b000100);
        reset = 1'b1;
        tick();
        checkOutput("midrst.strobes", strobes(), 6'b000000);
        checkOutput("midrst.depth", nest_depth, 2'd0);
        checkOutput("midrst.insvc", in_service, 1'b0);
        reset = 1'b0;
        applyStimulus(6'b000001, 1, 1, 0, 0);
        runEntry(6'b000001, 3'd0, 16'h0100, 2'd1, "restart");
        finishService(6'b000000, "restart");

        // Latency: request + instr_done in cycle N, reti pulse in NUM_LD must be ignored.
        applyStimulus(6'b001000, 1, 1, 0, 0);
        checkOutput("lat.isrld", strobes(), 6'b100000);
        checkOutput("lat.idx", active_idx, 3'd3);
        applyStimulus(6'b001000, 1, 0, 1, 0);
        checkOutput("lat.numld", strobes(), 6'b010000);
        applyStimulus(6'b001000, 1, 0, 0, 0);
        checkOutput("lat.save", strobes(), 6'b000100);
        applyStimulus(6'b001000, 1, 0, 0, 1);
        checkOutput("lat.savedrop", strobes(), 6'b000000);
        applyStimulus(6'b000000, 1, 0, 0, 0);
        checkOutput("lat.vec", strobes(), 6'b000001);
        checkOutput("lat.addr", vector_addr, 16'h0130);
        checkOutput("lat.idx3", active_idx, 3'd3);
        applyStimulus(6'b000100, 1, 1, 0, 0);
        checkOutput("lat.svcignore", strobes(), 6'b000000);
        checkOutput("lat.addrhold", vector_addr, 16'h0130);
        checkOutput("lat.idxhold", active_idx, 3'd3);
        finishService(6'b000000, "lat");

        // Fast beats normal; the normal request is taken after CLEAR.
        applyStimulus(6'b100010, 1, 1, 0, 0);
        runEntry(6'b100010, 3'd1, 16'h0110, 2'd1, "prio");
        finishService(6'b100000, "prio");
        applyStimulus(6'b100000, 1, 1, 0, 0);
        runEntry(6'b100000, 3'd5, 16'h0150, 2'd1, "late5");
        finishService(6'b000000, "late5");

        // WAIT drops back to IDLE when the request vanishes, and re-encodes each cycle.
        applyStimulus(6'b001000, 1, 0, 0, 0);
        applyStimulus(6'b000000, 1, 0, 0, 0);
        applyStimulus(6'b000000, 1, 1, 0, 0);
        checkOutput("wait.abandon", strobes(), 6'b000000);
        applyStimulus(6'b011000, 1, 0, 0, 0);
        applyStimulus(6'b010000, 1, 1, 0, 0);
        runEntry(6'b010000, 3'd4, 16'h0140, 2'd1, "wait");

`ifdef INTR_NEST_EN
        applyStimulus(6'b010001, 1, 1, 0, 0);
        runEntry(6'b010001, 3'd0, 16'h0100, 2'd2, "nest");
        applyStimulus(6'b010000, 1, 0, 1, 0);
        checkOutput("nest.restore", strobes(), 6'b000010);
        applyStimulus(6'b010000, 1, 0, 0, 1);
        checkOutput("nest.clr", strobes(), 6'b001000);
        applyStimulus(6'b000000, 1, 0, 0, 0);
        checkOutput("nest.revec", strobes(), 6'b000001);
        checkOutput("nest.readdr", vector_addr, 16'h0140);
        checkOutput("nest.reidx", active_idx, 3'd4);
        checkOutput("nest.redepth", nest_depth, 2'd1);
        checkOutput("nest.insvc", in_service, 1'b1);
        applyStimulus(6'b000000, 1, 0, 0, 0);
`else
        applyStimulus(6'b010001, 1, 1, 0, 0);
        checkOutput("nonest.strobes", strobes(), 6'b000000);
        checkOutput("nonest.depth", nest_depth, 2'd1);
        checkOutput("nonest.idx", active_idx, 3'd4);
        checkOutput("nonest.addr", vector_addr, 16'h0140);
`endif
        finishService(6'b000000, "outer");

        // Globally disabled interrupts produce no strobes at all.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(6'b000100, 0, (i % 2) == 1, 0, 0);
            checkOutput("disabled.strobes", strobes(), 6'b000000);
        end
        applyStimulus(6'b000100, 1, 1, 0, 0);
        runEntry(6'b000100, 3'd2, 16'h0120, 2'd1, "enable");
        finishService(6'b000000, "enable");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
